// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC redirect, hold/flush of PC, IF/ID and ID/EX,
// debug-halt drain and a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_req_i,
   input  logic              halt_req_i,
   output logic              pc_jump_en_o,
   output logic [ADDR_W-1:0] pc_jump_addr_o,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              halted_o,
   output logic [31:0]       stall_cycles_o
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_e;

   localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] DRAIN_LOAD  = 3'(DRAIN_CYCLES - 1);
   localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign pc_jump_addr_o = jump_addr_i;
   assign stall_cycles_o = stall_cnt_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stall_cnt_d   = stall_cnt_q;
      pc_jump_en_o  = 1'b0;
      hold_pc_o     = 1'b0;
      hold_if_id_o  = 1'b0;
      hold_id_ex_o  = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      halted_o      = 1'b0;

      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (jump_en_i) begin
                  pc_jump_en_o  = 1'b1;
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  if (FLUSH_MULTI) begin
                     cnt_d   = FLUSH_LOAD;
                     state_d = FLUSH;
                  end
               end else if (hold_req_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (halt_req_i) begin
                  hold_pc_o     = 1'b1;
                  flush_if_id_o = 1'b1;
                  cnt_d         = DRAIN_LOAD;
                  state_d       = DRAIN;
               end
            end
            FLUSH: begin
               // EX only carries a bubble here, so jump_en_i cannot be real
               flush_if_id_o = 1'b1;
               if (hold_req_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (cnt_q <= 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            DRAIN: begin
               flush_if_id_o = 1'b1;
               if (jump_en_i) begin
                  pc_jump_en_o  = 1'b1;
                  flush_id_ex_o = 1'b1;
                  cnt_d         = DRAIN_LOAD;
               end else if (hold_req_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (!halt_req_i) begin
                  hold_pc_o = 1'b1;
                  state_d   = RUN;
               end else if (cnt_q <= 3'd1) begin
                  hold_pc_o = 1'b1;
                  cnt_d     = 3'd0;
                  state_d   = HALTED;
               end else begin
                  hold_pc_o = 1'b1;
                  cnt_d     = cnt_q - 3'd1;
               end
            end
            HALTED: begin
               hold_pc_o     = 1'b1;
               flush_if_id_o = 1'b1;
               flush_id_ex_o = 1'b1;
               halted_o      = 1'b1;
               if (!halt_req_i) begin
                  state_d = RUN;
               end
            end
         endcase

         if (hold_pc_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= 3'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: redirect, hold, halt/drain, reset
// abandonment and stall counter saturation.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_req_i;
   logic        halt_req_i;
   logic        pc_jump_en_o;
   logic [31:0] pc_jump_addr_o;
   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic        flush_if_id_o;
   logic        flush_id_ex_o;
   logic        halted_o;
   logic [31:0] stall_cycles_o;

   int checks = 0;
   int errors = 0;

   // {jump, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, halted}
   logic [6:0] outs;
   assign outs = {pc_jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                  flush_if_id_o, flush_id_ex_o, halted_o};

   localparam logic [6:0] O_IDLE  = 7'b0000000;
   localparam logic [6:0] O_JUMP  = 7'b1000110;
   localparam logic [6:0] O_FLUSH = 7'b0000100;
   localparam logic [6:0] O_HOLD  = 7'b0111000;
   localparam logic [6:0] O_HOLDF = 7'b0111100;
   localparam logic [6:0] O_DRAIN = 7'b0100100;
   localparam logic [6:0] O_HALT  = 7'b0100111;

   pipe_ctrl #(
      .ADDR_W      (32),
      .FLUSH_CYCLES(2),
      .DRAIN_CYCLES(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .hold_req_i    (hold_req_i),
      .halt_req_i    (halt_req_i),
      .pc_jump_en_o  (pc_jump_en_o),
      .pc_jump_addr_o(pc_jump_addr_o),
      .hold_pc_o     (hold_pc_o),
      .hold_if_id_o  (hold_if_id_o),
      .hold_id_ex_o  (hold_id_ex_o),
      .flush_if_id_o (flush_if_id_o),
      .flush_id_ex_o (flush_id_ex_o),
      .halted_o      (halted_o),
      .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic j, input logic [31:0] a,
                        input logic h, input logic hl);
      @(negedge clk);
      rst         = r;
      jump_en_i   = j;
      jump_addr_i = a;
      hold_req_i  = h;
      halt_req_i  = hl;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 32'h44, 1'b1, 1'b1);
      checks++;
      if (outs !== O_IDLE) begin
         errors++;
         $display("FAIL reset_outs: got %b want %b", outs, O_IDLE);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (stall_cycles_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_stall: got %h want 0", stall_cycles_o);
      end
      checks++;
      if (outs !== O_IDLE) begin
         errors++;
         $display("FAIL reset_run_outs: got %b want %b", outs, O_IDLE);
      end
   endtask

   task automatic test_jump();
      logic [6:0] exp [4];
      exp = '{O_JUMP, O_FLUSH, O_IDLE, O_IDLE};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, (i == 0), 32'h100, 1'b0, 1'b0);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL jump_seq[%0d]: got %b want %b", i, outs, exp[i]);
         end
      end
      drive(1'b0, 1'b0, 32'hDEAD_BEE0, 1'b0, 1'b0);
      checks++;
      if (pc_jump_addr_o !== 32'hDEAD_BEE0) begin
         errors++;
         $display("FAIL jump_addr_pass: got %h want deadbee0", pc_jump_addr_o);
      end
   endtask

   task automatic test_hold();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         checks++;
         if (outs !== O_HOLD) begin
            errors++;
            $display("FAIL hold_run[%0d]: got %b want %b", i, outs, O_HOLD);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_IDLE || stall_cycles_o !== 32'd5) begin
         errors++;
         $display("FAIL hold_end: got %b/%0d want %b/5", outs, stall_cycles_o, O_IDLE);
      end
   endtask

   task automatic test_jump_hold();
      logic [6:0] exp [7];
      exp = '{O_JUMP, O_HOLDF, O_HOLDF, O_HOLDF, O_HOLDF, O_FLUSH, O_IDLE};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, (i == 0), 32'h200, (i < 5), 1'b0);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL jump_hold[%0d]: got %b want %b", i, outs, exp[i]);
         end
      end
      checks++;
      if (stall_cycles_o !== 32'd4) begin
         errors++;
         $display("FAIL jump_hold_stall: got %0d want 4", stall_cycles_o);
      end
   endtask

   task automatic test_halt();
      logic [6:0] exp [6];
      exp = '{O_DRAIN, O_DRAIN, O_HALT, O_HALT, O_HALT, O_IDLE};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, (i == 3), 32'h300, (i == 3), (i < 4));
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL halt_seq[%0d]: got %b want %b", i, outs, exp[i]);
         end
      end
      checks++;
      if (stall_cycles_o !== 32'd5) begin
         errors++;
         $display("FAIL halt_stall: got %0d want 5", stall_cycles_o);
      end
   endtask

   task automatic test_drain_jump();
      logic [6:0] exp [6];
      exp = '{O_DRAIN, O_JUMP, O_DRAIN, O_HALT, O_HALT, O_IDLE};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, (i == 1), 32'h2000, 1'b0, (i < 4));
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL drain_jump[%0d]: got %b want %b", i, outs, exp[i]);
         end
         if (i == 1) begin
            checks++;
            if (pc_jump_addr_o !== 32'h2000) begin
               errors++;
               $display("FAIL drain_jump_addr: got %h want 2000", pc_jump_addr_o);
            end
         end
         if (i == 3) begin
            checks++;
            if (stall_cycles_o !== 32'd2) begin
               errors++;
               $display("FAIL drain_jump_stall: got %0d want 2", stall_cycles_o);
            end
         end
      end
   endtask

   task automatic test_flush_reset();
      logic [6:0] exp [14];
      logic       r_v [14];
      logic       j_v [14];
      logic       hl_v [14];
      exp  = '{O_JUMP, O_FLUSH, O_IDLE, O_JUMP, O_IDLE, O_IDLE, O_DRAIN,
               O_IDLE, O_IDLE, O_DRAIN, O_DRAIN, O_HALT, O_IDLE, O_IDLE};
      r_v  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
      j_v  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      hl_v = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(r_v[i], j_v[i], 32'h300, 1'b0, hl_v[i]);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL flush_reset[%0d]: got %b want %b", i, outs, exp[i]);
         end
         if (i == 5 || i == 8 || i == 13) begin
            checks++;
            if (stall_cycles_o !== 32'd0) begin
               errors++;
               $display("FAIL flush_reset_stall[%0d]: got %0d want 0", i, stall_cycles_o);
            end
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      force dut.stall_cnt_d = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.stall_cnt_d;
      rst         = 1'b0;
      jump_en_i   = 1'b0;
      jump_addr_i = 32'h0;
      hold_req_i  = 1'b1;
      halt_req_i  = 1'b0;
      #1;
      checks++;
      if (stall_cycles_o !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL sat_preload: got %h want fffffffe", stall_cycles_o);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (stall_cycles_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_reach: got %h want ffffffff", stall_cycles_o);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (stall_cycles_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_nowrap: got %h want ffffffff", stall_cycles_o);
      end
   endtask

   initial begin
      rst         = 1'b1;
      jump_en_i   = 1'b0;
      jump_addr_i = 32'h0;
      hold_req_i  = 1'b0;
      halt_req_i  = 1'b0;
      test_reset();
      test_jump();
      test_hold();
      test_jump_hold();
      test_halt();
      test_drain_jump();
      test_flush_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
